// File: rtl/pmu_da_sequencer.sv
// PMU analog-test strobe sequencer: drives the DA_test1 pulse, then the
// DA_test2 window with a delayed DA_test3 dip, and reports done or abort.
module pmu_da_sequencer #(
  parameter int PULSE_MIN = 1000,
  parameter int GAP_MIN   = 2
) (
  input  logic        C_clk,
  input  logic        C_rst,
  input  logic        C_start,
  input  logic        C_abort,
  input  logic [15:0] C_pulse_len,
  input  logic [7:0]  C_gap_len,
  input  logic [3:0]  C_trim,
  output logic        DA_test1,
  output logic        DA_test2,
  output logic        DA_test3,
  output logic [3:0]  DA_test4,
  output logic        C_busy,
  output logic        C_done,
  output logic        C_abort_ack,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_GAP   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [15:0] PMIN = 16'(PULSE_MIN);
  localparam logic [7:0]  GMIN = 8'(GAP_MIN);

  state_e      state_q, state_d;
  logic [15:0] n1_q, n1_d;
  logic [7:0]  n2_q, n2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  trim_q, trim_d;
  logic        ack_d;
  logic        pulse_last, gap_last;

  // Widened compare so the counter never needs to wrap even at N1 = 65535.
  assign pulse_last = ({1'b0, cnt_q} + 17'd1) >= {1'b0, n1_q};
  assign gap_last   = (cnt_q + 16'd1) >= {8'd0, n2_q};

  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    cnt_d   = cnt_q;
    trim_d  = trim_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (C_start && !C_abort) begin
          n1_d    = (C_pulse_len < PMIN) ? PMIN : C_pulse_len;
          n2_d    = (C_gap_len < GMIN) ? GMIN : C_gap_len;
          trim_d  = C_trim;
          cnt_d   = 16'd0;
          state_d = S_PULSE;
        end
      end
      S_PULSE, S_GAP, S_HOLD: begin
        if (C_abort) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
          ack_d   = 1'b1;
        end else if ((state_q == S_PULSE) ? pulse_last : gap_last) begin
          cnt_d = 16'd0;
          case (state_q)
            S_PULSE: state_d = S_GAP;
            S_GAP:   state_d = S_HOLD;
            default: state_d = S_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge C_clk) begin
    if (C_rst) begin
      state_q     <= S_IDLE;
      n1_q        <= 16'd0;
      n2_q        <= 8'd0;
      cnt_q       <= 16'd0;
      trim_q      <= 4'd0;
      DA_test1    <= 1'b0;
      DA_test2    <= 1'b0;
      DA_test3    <= 1'b1;
      C_busy      <= 1'b0;
      C_done      <= 1'b0;
      C_abort_ack <= 1'b0;
    end else begin
      state_q     <= state_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      cnt_q       <= cnt_d;
      trim_q      <= trim_d;
      DA_test1    <= (state_d == S_PULSE);
      DA_test2    <= (state_d == S_GAP) || (state_d == S_HOLD);
      DA_test3    <= (state_d != S_HOLD);
      C_busy      <= (state_d == S_PULSE) || (state_d == S_GAP) || (state_d == S_HOLD);
      C_done      <= (state_d == S_DONE);
      C_abort_ack <= ack_d;
    end
  end

  assign DA_test4    = trim_q;
  assign dbg_state_o = state_q;

endmodule
